datapath: RTL and testbench

//  K&S processor datapath. Holds PC, IR, 4x16 register file, ALU and flags register.

---
 rtl/k_and_s_pkg.sv | 87 ++++++++
 rtl/datapath_if.sv | 41 ++++
 rtl/ks_alu.sv | 48 ++++
 rtl/datapath.sv | 129 ++++++++++++
 tb/tb_datapath.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/k_and_s_pkg.sv
// K&S processor shared definitions: instruction decode enum, opcodes, IR field
// positions and ALU operation/flag types used by datapath and ks_alu.
package k_and_s_pkg;

  localparam int KS_DATA_W = 16;
  localparam int KS_ADDR_W = 5;
  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = 2;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_HALT
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    ALU_OR  = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10,
    ALU_AND = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic unsigned_ov;
    logic signed_ov;
  } alu_flags_t;

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_LOAD   = 8'h01;
  localparam logic [7:0] OPC_STORE  = 8'h02;
  localparam logic [7:0] OPC_MOVE   = 8'h03;
  localparam logic [7:0] OPC_ADD    = 8'h04;
  localparam logic [7:0] OPC_SUB    = 8'h05;
  localparam logic [7:0] OPC_AND    = 8'h06;
  localparam logic [7:0] OPC_OR     = 8'h07;
  localparam logic [7:0] OPC_BRANCH = 8'h08;
  localparam logic [7:0] OPC_BZERO  = 8'h09;
  localparam logic [7:0] OPC_BNZERO = 8'h0A;
  localparam logic [7:0] OPC_BNEG   = 8'h0B;
  localparam logic [7:0] OPC_BNNEG  = 8'h0C;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

  // LSB positions of each IR field; widths are 8 (opcode), REG_IDX_W or ADDR_W.
  localparam int IR_OPC_LSB     = 8;
  localparam int IR_LS_REG_LSB  = 5;
  localparam int IR_MV_DST_LSB  = 2;
  localparam int IR_MV_SRC_LSB  = 0;
  localparam int IR_ALU_DST_LSB = 4;
  localparam int IR_ALU_A_LSB   = 2;
  localparam int IR_ALU_B_LSB   = 0;
  localparam int IR_TGT_LSB     = 0;

  function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
    decoded_instruction_type dec;
    case (opc)
      OPC_LOAD:   dec = I_LOAD;
      OPC_STORE:  dec = I_STORE;
      OPC_MOVE:   dec = I_MOVE;
      OPC_ADD:    dec = I_ADD;
      OPC_SUB:    dec = I_SUB;
      OPC_AND:    dec = I_AND;
      OPC_OR:     dec = I_OR;
      OPC_BRANCH: dec = I_BRANCH;
      OPC_BZERO:  dec = I_BZERO;
      OPC_BNZERO: dec = I_BNZERO;
      OPC_BNEG:   dec = I_BNEG;
      OPC_BNNEG:  dec = I_BNNEG;
      OPC_HALT:   dec = I_HALT;
      default:    dec = I_NOP;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Control/RAM-side bundle of the K&S datapath: strobes from control_unit,
// decode and flags back to it, and the RAM address/data signals.
interface datapath_if
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = KS_DATA_W,
  parameter int ADDR_W = KS_ADDR_W
) ();

  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    write_reg_enable;
  logic                    addr_sel;
  logic                    c_sel;
  alu_op_t                 operation;
  logic                    flags_reg_enable;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       data_out;
  logic [DATA_W-1:0]       data_in;

  modport master (
    output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
           operation, flags_reg_enable, data_in,
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );

  modport slave (
    input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
           operation, flags_reg_enable, data_in,
    output decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );

endinterface

// File: rtl/ks_alu.sv
// Combinational K&S ALU: modular OR/ADD/SUB/AND with zero, negative,
// unsigned-overflow (carry / borrow) and signed-overflow flags.
module ks_alu
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = KS_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_t           op_i,
  output logic [DATA_W-1:0] result_o,
  output alu_flags_t        flags_o
);

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;
  logic            sign_a;
  logic            sign_b;

  // The extra MSB is the carry for ADD and the borrow (A<B) for SUB.
  assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_ext = {1'b0, a_i} - {1'b0, b_i};
  assign sign_a   = a_i[DATA_W-1];
  assign sign_b   = b_i[DATA_W-1];

  always_comb begin
    result_o = '0;
    flags_o  = '0;
    case (op_i)
      ALU_OR: result_o = a_i | b_i;
      ALU_ADD: begin
        result_o            = sum_ext[DATA_W-1:0];
        flags_o.unsigned_ov = sum_ext[DATA_W];
        flags_o.signed_ov   = (sign_a == sign_b) && (result_o[DATA_W-1] != sign_a);
      end
      ALU_SUB: begin
        result_o            = diff_ext[DATA_W-1:0];
        flags_o.unsigned_ov = diff_ext[DATA_W];
        flags_o.signed_ov   = (sign_a != sign_b) && (result_o[DATA_W-1] != sign_a);
      end
      ALU_AND: result_o = a_i & b_i;
      default: result_o = '0;
    endcase
    flags_o.zero = (result_o == '0);
    flags_o.neg  = result_o[DATA_W-1];
  end

endmodule

// File: rtl/datapath.sv
// K&S processor datapath: PC, IR, 4x16 register file, ALU and flags register.
// Define KS_R0_HARDWIRED_ZERO_EN to make R0 read as 0 and ignore writes to it.
module datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = KS_DATA_W,
  parameter int ADDR_W = KS_ADDR_W
) (
  input logic       clk,
  input logic       rst_n,
  datapath_if.slave dp_if
);

`ifdef KS_R0_HARDWIRED_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]    ir_q, ir_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic [DATA_W-1:0]    reg_view [NUM_REGS];
  alu_flags_t           flags_q, flags_d;

  logic [7:0]           opcode;
  logic                 is_move;
  logic [REG_IDX_W-1:0] src_a_idx;
  logic [REG_IDX_W-1:0] src_b_idx;
  logic [REG_IDX_W-1:0] dst_idx;
  logic [REG_IDX_W-1:0] store_idx;
  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic [DATA_W-1:0]    alu_res;
  logic [DATA_W-1:0]    wb_data;
  alu_flags_t           alu_flags;
  logic                 unused_ir_bit;

  assign opcode        = ir_q[IR_OPC_LSB +: 8];
  assign is_move       = (opcode == OPC_MOVE);
  assign store_idx     = ir_q[IR_LS_REG_LSB +: REG_IDX_W];
  assign unused_ir_bit = ir_q[7];

  // Read view of the register file; reads are asynchronous so a same-cycle
  // write is only visible after the edge.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_view
    if (gi == 0 && R0_ZERO) begin : g_zero
      assign reg_view[gi] = '0;
    end else begin : g_reg
      assign reg_view[gi] = regs_q[gi];
    end
  end

  always_comb begin : operand_select
    src_a_idx = is_move ? ir_q[IR_MV_SRC_LSB +: REG_IDX_W]
                        : ir_q[IR_ALU_A_LSB +: REG_IDX_W];
    src_b_idx = ir_q[IR_ALU_B_LSB +: REG_IDX_W];
    case (opcode)
      OPC_LOAD: dst_idx = ir_q[IR_LS_REG_LSB +: REG_IDX_W];
      OPC_MOVE: dst_idx = ir_q[IR_MV_DST_LSB +: REG_IDX_W];
      default:  dst_idx = ir_q[IR_ALU_DST_LSB +: REG_IDX_W];
    endcase
  end

  // MOVE forces B to zero so an OR passes the source register through.
  assign alu_a = reg_view[src_a_idx];
  assign alu_b = is_move ? '0 : reg_view[src_b_idx];

  ks_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (dp_if.operation),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  assign wb_data = dp_if.c_sel ? dp_if.data_in : alu_res;

  always_comb begin : next_state
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (dp_if.pc_enable) begin
      pc_d = dp_if.branch ? ir_q[IR_TGT_LSB +: ADDR_W] : pc_q + ADDR_W'(1);
    end
    if (dp_if.ir_enable) begin
      ir_d = dp_if.data_in;
    end
    if (dp_if.flags_reg_enable) begin
      flags_d = alu_flags;
    end
    if (dp_if.write_reg_enable && !(R0_ZERO && dst_idx == '0)) begin
      regs_d[dst_idx] = wb_data;
    end
  end

  always_ff @(posedge clk) begin : state_regs
    if (!rst_n) begin
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign dp_if.decoded_instruction = decode_opcode(opcode);
  assign dp_if.zero_op             = flags_q.zero;
  assign dp_if.neg_op              = flags_q.neg;
  assign dp_if.unsigned_overflow   = flags_q.unsigned_ov;
  assign dp_if.signed_overflow     = flags_q.signed_ov;
  assign dp_if.ram_addr            = dp_if.addr_sel ? pc_q : ir_q[IR_TGT_LSB +: ADDR_W];
  assign dp_if.data_out            = reg_view[store_idx];

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed steps followed by random strobes,
// all compared against a behavioural model of PC/IR/registers/flags.
module tb_datapath;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  datapath_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp_if (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [15:0] m_reg [4];
  logic [4:0]  m_pc;
  logic [15:0] m_ir;
  logic        m_fz, m_fn, m_fu, m_fs;

  function automatic logic [15:0] m_rd(input int idx);
`ifdef KS_R0_HARDWIRED_ZERO_EN
    if (idx == 0) return 16'h0000;
`endif
    return m_reg[idx];
  endfunction

  function automatic decoded_instruction_type exp_dec(input logic [7:0] opc);
    case (opc)
      8'h01: return I_LOAD;
      8'h02: return I_STORE;
      8'h03: return I_MOVE;
      8'h04: return I_ADD;
      8'h05: return I_SUB;
      8'h06: return I_AND;
      8'h07: return I_OR;
      8'h08: return I_BRANCH;
      8'h09: return I_BZERO;
      8'h0A: return I_BNZERO;
      8'h0B: return I_BNEG;
      8'h0C: return I_BNNEG;
      8'hFF: return I_HALT;
      default: return I_NOP;
    endcase
  endfunction

  // Arithmetic done on plain integers; overflow means the true result leaves the range.
  task automatic m_alu(input int op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic z, output logic n,
                       output logic uo, output logic so);
    int ua, ub, sa, sb, r;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    uo = 1'b0; so = 1'b0;
    case (op)
      0: res = a | b;
      1: begin
        r = ua + ub; res = 16'(r); uo = (r > 65535);
        r = sa + sb; so = (r > 32767) || (r < -32768);
      end
      2: begin
        res = 16'(ua - ub); uo = (ua < ub);
        r = sa - sb; so = (r > 32767) || (r < -32768);
      end
      default: res = a & b;
    endcase
    z = (res == 16'h0000);
    n = res[15];
  endtask

  task automatic cyc();
    logic [15:0] n_reg [4];
    logic [15:0] n_ir, a, b, res;
    logic [4:0]  n_pc;
    logic        z, n, uo, so;
    logic        nz, nn, nu, ns;
    int          opc, dst;
    n_reg = m_reg; n_ir = m_ir; n_pc = m_pc;
    nz = m_fz; nn = m_fn; nu = m_fu; ns = m_fs;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) n_reg[i] = 16'h0000;
      n_ir = 16'h0000; n_pc = 5'd0;
      nz = 0; nn = 0; nu = 0; ns = 0;
    end else begin
      opc = int'(m_ir[15:8]);
      if (opc == 3) begin
        a = m_rd(int'(m_ir[1:0])); b = 16'h0000;
      end else begin
        a = m_rd(int'(m_ir[3:2])); b = m_rd(int'(m_ir[1:0]));
      end
      m_alu(int'(bus.operation), a, b, res, z, n, uo, so);
      if (bus.flags_reg_enable) begin
        nz = z; nn = n; nu = uo; ns = so;
      end
      if (bus.write_reg_enable) begin
        if (opc == 1)      dst = int'(m_ir[6:5]);
        else if (opc == 3) dst = int'(m_ir[3:2]);
        else               dst = int'(m_ir[5:4]);
        n_reg[dst] = bus.c_sel ? bus.data_in : res;
      end
      if (bus.ir_enable) n_ir = bus.data_in;
      if (bus.pc_enable) n_pc = bus.branch ? m_ir[4:0] : 5'((int'(m_pc) + 1) % 32);
    end
    @(posedge clk);
    #1;
    m_reg = n_reg; m_ir = n_ir; m_pc = n_pc;
    m_fz = nz; m_fn = nn; m_fu = nu; m_fs = ns;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dec"}, 32'(bus.decoded_instruction), 32'(exp_dec(m_ir[15:8])));
    chk({tag, ".addr"}, 32'(bus.ram_addr), 32'(bus.addr_sel ? m_pc : m_ir[4:0]));
    chk({tag, ".dout"}, 32'(bus.data_out), 32'(m_rd(int'(m_ir[6:5]))));
    chk({tag, ".flags"},
        32'({bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow}),
        32'({m_fz, m_fn, m_fu, m_fs}));
  endtask

  task automatic idle();
    bus.branch = 0; bus.pc_enable = 0; bus.ir_enable = 0; bus.write_reg_enable = 0;
    bus.addr_sel = 0; bus.c_sel = 0; bus.operation = ALU_OR; bus.flags_reg_enable = 0;
    bus.data_in = 16'h0000;
  endtask

  task automatic set_ir(input logic [15:0] w);
    idle(); bus.ir_enable = 1; bus.data_in = w;
    cyc(); check_all("ir");
    idle(); #1;
  endtask

  task automatic exec(input logic we, input logic csel, input alu_op_t op,
                      input logic fen, input logic [15:0] din);
    idle();
    bus.write_reg_enable = we; bus.c_sel = csel; bus.operation = op;
    bus.flags_reg_enable = fen; bus.data_in = din;
    cyc(); check_all("exec");
    idle(); #1;
  endtask

  logic [7:0] opc_tab [15];

  initial begin
    opc_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hFF, 8'h3C};

    // Reset overrides every strobe
    rst_n = 0;
    bus.branch = 1; bus.pc_enable = 1; bus.ir_enable = 1; bus.write_reg_enable = 1;
    bus.addr_sel = 1; bus.c_sel = 1; bus.operation = ALU_ADD; bus.flags_reg_enable = 1;
    bus.data_in = 16'hFFFF;
    cyc(); check_all("reset");
    chk("rst_dec", 32'(bus.decoded_instruction), 32'(I_NOP));
    chk("rst_pc", 32'(bus.ram_addr), 32'd0);
    chk("rst_flags", 32'({bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow}), 32'd0);
    rst_n = 1; idle();

    // Fetch from PC=5
    repeat (5) begin
      idle(); bus.pc_enable = 1; cyc();
    end
    idle(); bus.addr_sel = 1; #1;
    chk("pc5", 32'(bus.ram_addr), 32'd5);
    bus.ir_enable = 1; bus.pc_enable = 1; bus.data_in = 16'h0401;
    cyc(); check_all("fetch");
    chk("fetch_pc", 32'(bus.ram_addr), 32'd6);
    chk("fetch_dec", 32'(bus.decoded_instruction), 32'(I_ADD));
    idle(); #1;
    chk("fetch_ir_lo", 32'(bus.ram_addr), 32'h01);

    // LOAD/ADD signed overflow
    set_ir(16'h0120); exec(1, 1, ALU_OR, 0, 16'h7FFF);
    set_ir(16'h0140); exec(1, 1, ALU_OR, 0, 16'h0001);
    set_ir(16'h0436); exec(1, 0, ALU_ADD, 1, 16'h0000);
    chk("add_flags", 32'({bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow}), 32'b0101);
    set_ir(16'h0260);
    chk("add_r3", 32'(bus.data_out), 32'h8000);

    // SUB borrow and zero result
    set_ir(16'h0120); exec(1, 1, ALU_OR, 0, 16'h0001);
    set_ir(16'h0140); exec(1, 1, ALU_OR, 0, 16'h0002);
    set_ir(16'h0506); exec(1, 0, ALU_SUB, 1, 16'h0000);
    chk("sub_flags", 32'({bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow}), 32'b0110);
    set_ir(16'h0200);
`ifdef KS_R0_HARDWIRED_ZERO_EN
    chk("sub_r0", 32'(bus.data_out), 32'h0000);
`else
    chk("sub_r0", 32'(bus.data_out), 32'hFFFF);
`endif
    set_ir(16'h0505); exec(0, 0, ALU_SUB, 1, 16'h0000);
    chk("sub_eq_flags", 32'({bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow}), 32'b1000);

    // Branch, wrap, and IR/PC loaded in the same cycle
    set_ir(16'h081F);
    bus.pc_enable = 1; bus.branch = 1; bus.addr_sel = 1;
    cyc(); check_all("br31"); chk("br31_pc", 32'(bus.ram_addr), 32'd31);
    idle(); bus.pc_enable = 1; bus.addr_sel = 1;
    cyc(); check_all("wrap"); chk("wrap_pc", 32'(bus.ram_addr), 32'd0);
    set_ir(16'h0808);
    bus.pc_enable = 1; bus.branch = 1; bus.ir_enable = 1; bus.data_in = 16'h0A03; bus.addr_sel = 1;
    cyc(); check_all("br_ir");
    chk("br_old_ir_pc", 32'(bus.ram_addr), 32'd8);
    chk("br_new_dec", 32'(bus.decoded_instruction), 32'(I_BNZERO));
    idle(); bus.pc_enable = 1; bus.branch = 1; bus.addr_sel = 1;
    cyc(); chk("br_new_pc", 32'(bus.ram_addr), 32'd3);

    // MOVE and STORE addressing
    set_ir(16'h030D); exec(1, 0, ALU_OR, 0, 16'h0000);
    set_ir(16'h0260);
    chk("move_r3", 32'(bus.data_out), 32'h0001);
    set_ir(16'h027A);
    chk("store_addr", 32'(bus.ram_addr), 32'h1A);
    chk("store_data", 32'(bus.data_out), 32'h0001);
`ifdef KS_R0_HARDWIRED_ZERO_EN
    set_ir(16'h0100); exec(1, 1, ALU_OR, 0, 16'h1234);
    set_ir(16'h0200);
    chk("r0_hardwired", 32'(bus.data_out), 32'h0000);
`endif

    // Random strobes against the model
    for (int i = 0; i < 400; i++) begin
      rst_n                = ($urandom_range(0, 63) != 0);
      bus.branch           = 1'($urandom_range(0, 1));
      bus.pc_enable        = 1'($urandom_range(0, 1));
      bus.ir_enable        = 1'($urandom_range(0, 1));
      bus.write_reg_enable = 1'($urandom_range(0, 1));
      bus.addr_sel         = 1'($urandom_range(0, 1));
      bus.c_sel            = 1'($urandom_range(0, 1));
      bus.flags_reg_enable = 1'($urandom_range(0, 1));
      bus.operation        = alu_op_t'(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) != 0)
        bus.data_in = {opc_tab[$urandom_range(0, 14)], 8'($urandom)};
      else
        bus.data_in = 16'($urandom);
      cyc(); check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
